isqrt_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one fast inverse-square-root datapath
//  (64-bit IEEE-754 double in x_bits, 1/sqrt(x) out y_bits) among NUM_REQ

---
 rtl/isqrt_pkg.sv | 55 +++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/isqrt_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_isqrt_rr_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and IEEE-754 double constants for the isqrt round-robin scheduler.
// classify() supports the ISQRT_SPECIAL_EN special-operand bypass.
package isqrt_pkg;

   localparam int unsigned DOUBLE_W = 64;
   localparam int unsigned SIGN_W   = 1;
   localparam int unsigned EXP_W    = 11;
   localparam int unsigned MANT_W   = 52;

   localparam logic [DOUBLE_W-1:0] DOUBLE_POS_INF = 64'h7FF0_0000_0000_0000;
   localparam logic [DOUBLE_W-1:0] DOUBLE_QNAN    = 64'h7FF8_0000_0000_0000;
   localparam logic [DOUBLE_W-1:0] DOUBLE_ZERO    = 64'h0000_0000_0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  expo;
      logic [MANT_W-1:0] mant;
   } double_t;

   typedef struct packed {
      logic                hit;
      logic [DOUBLE_W-1:0] value;
   } special_t;

   // Operands whose 1/sqrt is fixed by IEEE rules rather than computed.
   function automatic special_t classify(input double_t x);
      special_t r;
      logic     exp_max;
      logic     mant_zero;
      r.hit     = 1'b1;
      r.value   = DOUBLE_QNAN;
      exp_max   = &x.expo;
      mant_zero = ~|x.mant;
      if (x.expo == '0 && mant_zero) begin
         r.value = DOUBLE_POS_INF;
      end else if (exp_max && !mant_zero) begin
         r.value = DOUBLE_QNAN;
      end else if (x.sign[0]) begin
         r.value = DOUBLE_QNAN;
      end else if (exp_max) begin
         r.value = DOUBLE_ZERO;
      end else begin
         r.hit = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = IDX_W'((32'(ptr) + 32'(k)) % NUM_REQ);
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/isqrt_rr_scheduler.sv
// Round-robin scheduler sharing one inverse-square-root datapath among NUM_REQ clients.
// Define ISQRT_SPECIAL_EN to answer zero/inf/NaN/negative operands without the datapath.
module isqrt_rr_scheduler
   import isqrt_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned DP_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_x,
   output logic                      dp_start,
   output logic [DATA_W-1:0]         dp_x_bits,
   input  logic [DATA_W-1:0]         dp_y_bits,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]         rsp_y,
   output logic                      busy
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = (DP_LATENCY > 0) ? $clog2(DP_LATENCY + 1) : 1;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    ptr, ptr_nxt;
   logic [IDX_W-1:0]    tag, tag_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [DATA_W-1:0]   x_nxt, y_nxt;
   logic [NUM_REQ-1:0]  rsp_valid_nxt;
   logic                dp_start_nxt, busy_nxt;
   logic [NUM_REQ-1:0]  grant;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_any;
   logic [DATA_W-1:0]   req_x_arr [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_x_arr[i] = req_x[i*DATA_W +: DATA_W];
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

`ifdef ISQRT_SPECIAL_EN
   special_t special;
   always_comb special = classify(double_t'(64'(req_x_arr[grant_idx])));
`endif

   // Next-state, datapath sequencing and next values of the registered outputs.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      tag_nxt   = tag;
      cnt_nxt   = cnt;
      x_nxt     = dp_x_bits;
      y_nxt     = rsp_y;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (grant_any) begin
               req_ready = grant;
               tag_nxt   = grant_idx;
               ptr_nxt   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
               x_nxt     = req_x_arr[grant_idx];
`ifdef ISQRT_SPECIAL_EN
               if (special.hit) begin
                  y_nxt     = DATA_W'(special.value);
                  state_nxt = RESP;
               end else begin
                  state_nxt = ISSUE;
               end
`else
               state_nxt = ISSUE;
`endif
            end
         end
         ISSUE: begin
            cnt_nxt = CNT_W'(DP_LATENCY);
            if (DP_LATENCY == 0) begin
               y_nxt     = dp_y_bits;
               state_nxt = RESP;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt <= CNT_W'(1)) begin
               y_nxt     = dp_y_bits;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready[tag]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      rsp_valid_nxt = (state_nxt == RESP) ? (NUM_REQ'(1) << tag_nxt) : '0;
      dp_start_nxt  = (state_nxt == ISSUE);
      busy_nxt      = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         tag       <= '0;
         cnt       <= '0;
         dp_x_bits <= '0;
         rsp_y     <= '0;
         rsp_valid <= '0;
         dp_start  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         tag       <= tag_nxt;
         cnt       <= cnt_nxt;
         dp_x_bits <= x_nxt;
         rsp_y     <= y_nxt;
         rsp_valid <= rsp_valid_nxt;
         dp_start  <= dp_start_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_isqrt_rr_scheduler.sv
// Directed bench for isqrt_rr_scheduler: three instances (DP_LATENCY 1, 0, 3)
// each driven by a behavioural 1/sqrt datapath with matching latency.
module tb_isqrt_rr_scheduler;

   localparam logic [63:0] X4    = 64'h4010_0000_0000_0000;
   localparam logic [63:0] X9    = 64'h4022_0000_0000_0000;
   localparam logic [63:0] X2    = 64'h4000_0000_0000_0000;
   localparam logic [63:0] XQ    = 64'h3FD0_0000_0000_0000;
   localparam logic [63:0] YHALF = 64'h3FE0_0000_0000_0000;

   logic clk, rst;
   int total, bad;

   logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [255:0] req_x;
   logic         dp_start, busy;
   logic [63:0]  dp_x, dp_y, rsp_y, x_d1;

   logic [3:0]   rv0, rdy0, vld0, rr0, rv3, rdy3, vld3, rr3;
   logic [255:0] rx0, rx3;
   logic         ds0, ds3, busy0, busy3;
   logic [63:0]  dx0, dy0, ry0, dx3, dy3, ry3, d3_1, d3_2, d3_3;

   function automatic logic [63:0] isq(input logic [63:0] x);
      return $realtobits(1.0 / $sqrt($bitstoreal(x)));
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      x_d1 <= dp_x;
      d3_1 <= dx3;
      d3_2 <= d3_1;
      d3_3 <= d3_2;
   end
   assign dp_y = isq(x_d1);
   assign dy0  = isq(dx0);
   assign dy3  = isq(d3_3);

   isqrt_rr_scheduler #(.NUM_REQ(4), .DATA_W(64), .DP_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
      .dp_start(dp_start), .dp_x_bits(dp_x), .dp_y_bits(dp_y), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_y(rsp_y), .busy(busy));

   isqrt_rr_scheduler #(.NUM_REQ(4), .DATA_W(64), .DP_LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_x(rx0),
      .dp_start(ds0), .dp_x_bits(dx0), .dp_y_bits(dy0), .rsp_valid(vld0),
      .rsp_ready(rr0), .rsp_y(ry0), .busy(busy0));

   isqrt_rr_scheduler #(.NUM_REQ(4), .DATA_W(64), .DP_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rdy3), .req_x(rx3),
      .dp_start(ds3), .dp_x_bits(dx3), .dp_y_bits(dy3), .rsp_valid(vld3),
      .rsp_ready(rr3), .rsp_y(ry3), .busy(busy3));

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      total++;
      if (req_ready !== 4'b0 || rsp_valid !== 4'b0) begin
         bad++;
         $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b want 0000/0000", req_ready, rsp_valid);
      end
      total++;
      if (dp_start !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: dp_start=%b busy=%b want 0/0", dp_start, busy);
      end
      total++;
      if (dp_x !== 64'h0 || rsp_y !== 64'h0) begin
         bad++;
         $display("FAIL reset_data: dp_x=%h rsp_y=%h want 0/0", dp_x, rsp_y);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      int lat = 0;
      logic seen = 1'b0;
      real a;
      req_x[63:0] = X4;
      req_valid   = 4'b0001;
      rsp_ready   = 4'b0000;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL single_grant: req_ready=%b want 0001", req_ready);
      end
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            req_valid = 4'b0;
            total++;
            if (dp_start !== 1'b1 || dp_x !== X4) begin
               bad++;
               $display("FAIL single_issue: dp_start=%b dp_x=%h want 1/%h", dp_start, dp_x, X4);
            end
         end
         if (rsp_valid != 4'b0) seen = 1'b1;
      end
      total++;
      if (!seen || lat != 3) begin
         bad++;
         $display("FAIL single_latency: got %0d cycles (seen=%b) want 3", lat, seen);
      end
      a = $bitstoreal(rsp_y);
      total++;
      if (rsp_valid !== 4'b0001 || busy !== 1'b1 || a < 0.5 - 1e-9 || a > 0.5 + 1e-9) begin
         bad++;
         $display("FAIL single_rsp: rsp_valid=%b busy=%b rsp_y=%h want 0001/1/~%h", rsp_valid, busy, rsp_y, YHALF);
      end
      rsp_ready = 4'b0001;
      @(negedge clk);
      total++;
      if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_done: rsp_valid=%b busy=%b want 0000/0", rsp_valid, busy);
      end
      rsp_ready = 4'b0;
   endtask

   task automatic test_rr();
      int  exp_g [5];
      real exp_y [4];
      int  n_g = 0, n_r = 0, cyc = 0;
      real a, e;
      exp_g = '{0, 1, 2, 3, 0};
      exp_y = '{0.5, 1.0 / 3.0, 0.7071067811865476, 2.0};
      do_reset();
      rsp_ready = 4'b1111;
      req_x     = {XQ, X2, X9, X4};
      req_valid = 4'b1111;
      while (n_r < 5 && cyc < 100) begin
         #1;
         if (req_ready != 4'b0) begin
            total++;
            if (n_g >= 5 || req_ready !== (4'b1 << exp_g[n_g])) begin
               bad++;
               $display("FAIL rr_grant%0d: req_ready=%b want %b", n_g, req_ready,
                        (n_g < 5) ? (4'b1 << exp_g[n_g]) : 4'b0);
            end
            n_g++;
         end
         if (rsp_valid != 4'b0) begin
            a = $bitstoreal(rsp_y);
            e = exp_y[exp_g[n_r]];
            total++;
            if (rsp_valid !== (4'b1 << exp_g[n_r]) || a < e - 1e-9 || a > e + 1e-9) begin
               bad++;
               $display("FAIL rr_rsp%0d: rsp_valid=%b rsp_y=%f want %b/%f", n_r, rsp_valid, a,
                        4'b1 << exp_g[n_r], e);
            end
            n_r++;
         end
         @(negedge clk);
         cyc++;
         if (n_g >= 5) req_valid = 4'b0;
      end
      total++;
      if (n_r != 5 || n_g != 5) begin
         bad++;
         $display("FAIL rr_count: grants=%0d responses=%0d want 5/5", n_g, n_r);
      end
      req_valid = 4'b0;
   endtask

   task automatic test_stall();
      int cyc = 0;
      do_reset();
      rsp_ready            = 4'b0000;
      req_x[2*64 +: 64]    = X4;
      req_valid            = 4'b0100;
      #1;
      total++;
      if (req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL stall_grant: req_ready=%b want 0100", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0;
      while (rsp_valid == 4'b0 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      req_x[63:0] = X9;
      req_valid   = 4'b0001;
      rsp_ready   = 4'b1011;
      for (int i = 0; i < 10; i++) begin
         #1;
         total++;
         if (rsp_valid !== 4'b0100 || rsp_y !== YHALF) begin
            bad++;
            $display("FAIL stall_hold%0d: rsp_valid=%b rsp_y=%h want 0100/%h", i, rsp_valid, rsp_y, YHALF);
         end
         total++;
         if (req_ready !== 4'b0 || dp_start !== 1'b0) begin
            bad++;
            $display("FAIL stall_quiet%0d: req_ready=%b dp_start=%b want 0000/0", i, req_ready, dp_start);
         end
         @(negedge clk);
      end
      rsp_ready = 4'b1111;
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 4'b0 || req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL stall_release: rsp_valid=%b req_ready=%b want 0000/0001", rsp_valid, req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      req_x[64 +: 64] = X9;
      req_valid       = 4'b0010;
      rsp_ready       = 4'b1111;
      #1;
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL rmid_grant: req_ready=%b want 0010", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || dp_start !== 1'b0 || busy !== 1'b0 ||
          dp_x !== 64'h0 || rsp_y !== 64'h0) begin
         bad++;
         $display("FAIL rmid_clear: rdy=%b vld=%b ds=%b busy=%b dp_x=%h rsp_y=%h want all 0",
                  req_ready, rsp_valid, dp_start, busy, dp_x, rsp_y);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 4'b0 || rsp_y !== 64'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_stale%0d: rsp_valid=%b rsp_y=%h busy=%b want 0000/0/0", i, rsp_valid, rsp_y, busy);
         end
      end
      req_x     = {X4, X4, X4, X4};
      req_valid = 4'b1111;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL rmid_next: req_ready=%b want 0001", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_latency();
      int cyc = 0, l0 = 0, l3 = 0;
      rx0[63:0] = X4;
      rx3[63:0] = X4;
      rr0 = 4'b1111;
      rr3 = 4'b1111;
      rv0 = 4'b0001;
      rv3 = 4'b0001;
      #1;
      total++;
      if (rdy0 !== 4'b0001 || rdy3 !== 4'b0001) begin
         bad++;
         $display("FAIL lat_grant: rdy0=%b rdy3=%b want 0001/0001", rdy0, rdy3);
      end
      while (cyc < 20 && (l0 == 0 || l3 == 0)) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            rv0 = 4'b0;
            rv3 = 4'b0;
         end
         if (vld0 != 4'b0 && l0 == 0) begin
            l0 = cyc;
            total++;
            if (ry0 !== YHALF) begin
               bad++;
               $display("FAIL lat0_value: rsp_y=%h want %h", ry0, YHALF);
            end
         end
         if (vld3 != 4'b0 && l3 == 0) begin
            l3 = cyc;
            total++;
            if (ry3 !== YHALF) begin
               bad++;
               $display("FAIL lat3_value: rsp_y=%h want %h", ry3, YHALF);
            end
         end
      end
      total++;
      if (l0 != 2) begin
         bad++;
         $display("FAIL lat0_cycles: got %0d want 2", l0);
      end
      total++;
      if (l3 != 5) begin
         bad++;
         $display("FAIL lat3_cycles: got %0d want 5", l3);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_special();
      logic [63:0] xs [3];
      logic [63:0] ys [3];
      int   lat;
      logic seen, saw_dp;
      xs = '{64'h0, 64'hBFF0_0000_0000_0000, 64'h7FF0_0000_0000_0000};
      ys = '{64'h7FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h0};
      rsp_ready = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         req_x[63:0] = xs[i];
         req_valid   = 4'b0001;
         lat    = 0;
         seen   = 1'b0;
         saw_dp = 1'b0;
         #1;
         total++;
         if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL special%0d_grant: req_ready=%b want 0001", i, req_ready);
         end
         while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) req_valid = 4'b0;
            if (dp_start) saw_dp = 1'b1;
            if (rsp_valid != 4'b0) seen = 1'b1;
         end
`ifdef ISQRT_SPECIAL_EN
         total++;
         if (!seen || lat != 1 || saw_dp !== 1'b0 || rsp_y !== ys[i]) begin
            bad++;
            $display("FAIL special%0d: lat=%0d dp_start_seen=%b rsp_y=%h want 1/0/%h", i, lat, saw_dp, rsp_y, ys[i]);
         end
`else
         total++;
         if (!seen || lat != 3 || saw_dp !== 1'b1) begin
            bad++;
            $display("FAIL nospecial%0d: lat=%0d dp_start_seen=%b want 3/1 (bypass would give %h)", i, lat, saw_dp, ys[i]);
         end
`endif
         @(negedge clk);
      end
      rsp_ready = 4'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      req_valid = '0; rsp_ready = '0; req_x = '0;
      rv0 = '0; rr0 = '0; rx0 = '0;
      rv3 = '0; rr3 = '0; rx3 = '0;
      test_reset();
      test_single();
      test_rr();
      test_stall();
      test_reset_mid();
      test_latency();
      test_special();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
